// File: rtl/nibbler_pkg.sv
// rtl/nibbler_pkg.sv - shared types and widths for the nibble input front-end
package nibbler_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS_DB = 3'd1,
        LOAD     = 3'd2,
        WAIT_REL = 3'd3,
        REL_DB   = 3'd4
    } in_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - W-bit two-flop synchroniser for asynchronous inputs
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two back-to-back flops; the first may go metastable, the second settles it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nibble_in_ctrl.sv
// rtl/nibble_in_ctrl.sv - synchronise switches/button, debounce button, capture nibble with load strobe
module nibble_in_ctrl
    import nibbler_pkg::*;
#(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_raw,
    input  logic [NIBBLE_W-1:0] sw_raw,
    output logic [NIBBLE_W-1:0] nibble,
    output logic                load,
    output logic                busy,
    output logic [7:0]          load_cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic                btn_s;
    logic [NIBBLE_W-1:0] sw_s;

    in_state_t           state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [NIBBLE_W-1:0] nibble_d;
    logic                load_d;
    logic [7:0]          load_cnt_d;

    sync_2ff #(.W(1)) u_sync_btn (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (btn_s)
    );

    sync_2ff #(.W(NIBBLE_W)) u_sync_sw (
        .clk   (clk),
        .reset (reset),
        .d     (sw_raw),
        .q     (sw_s)
    );

    // State, debounce counter and all outputs are registered together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            nibble   <= '0;
            load     <= 1'b0;
            busy     <= 1'b0;
            load_cnt <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            nibble   <= nibble_d;
            load     <= load_d;
            busy     <= (state_d != IDLE);
            load_cnt <= load_cnt_d;
        end
    end

    // Next-state: press must be stable DEB_CYCLES before load, release likewise before re-arming
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        nibble_d   = nibble;
        load_d     = 1'b0;
        load_cnt_d = load_cnt;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_DB;
                    cnt_d   = '0;
                end
            end
            PRESS_DB: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_d    = LOAD;
                    nibble_d   = sw_s;
                    load_d     = 1'b1;
                    load_cnt_d = load_cnt + 8'd1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            LOAD: begin
                state_d = WAIT_REL;
            end
            WAIT_REL: begin
                if (!btn_s) begin
                    state_d = REL_DB;
                    cnt_d   = '0;
                end
            end
            REL_DB: begin
                if (btn_s) begin
                    state_d = WAIT_REL;
                end else if (cnt == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nibble_in_ctrl.sv
// tb/tb_nibble_in_ctrl.sv - scoreboard bench for nibble_in_ctrl with DEB_CYCLES=4
module tb_nibble_in_ctrl;

    logic       clk;
    logic       reset;
    logic       btn_raw;
    logic [3:0] sw_raw;
    logic [3:0] nibble;
    logic       load;
    logic       busy;
    logic [7:0] load_cnt;

    int n_cmp;
    int n_err;
    int loads_seen;
    int first_k;
    int base;
    logic prev_load;
    logic saw_hi, saw_lo;
    logic [7:0]  exp_cnt;
    logic [11:0] exp_q[$];
    logic [11:0] mon_e;

    nibble_in_ctrl #(
        .DEB_CYCLES (4),
        .CNT_W      (20)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .sw_raw   (sw_raw),
        .nibble   (nibble),
        .load     (load),
        .busy     (busy),
        .load_cnt (load_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [3:0] n);
        exp_cnt = exp_cnt + 8'd1;
        exp_q.push_back({n, exp_cnt});
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset   = 1'b0;
        btn_raw = 1'b0;
        sw_raw  = 4'h0;
        exp_q.delete();
        exp_cnt = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic measure(output int fk, input int n);
        fk = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (load && fk == 0) fk = k;
        end
    endtask

    // Load monitor: every strobe pops the scoreboard and must be one cycle wide
    always @(negedge clk) begin
        if (reset) begin
            if (load) begin
                loads_seen++;
                chk("load_single", {31'd0, prev_load}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_load", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("nibble", {28'd0, nibble}, {28'd0, mon_e[11:8]});
                    chk("load_cnt", {24'd0, load_cnt}, {24'd0, mon_e[7:0]});
                end
            end
            prev_load = load;
        end else begin
            prev_load = 1'b0;
        end
    end

    initial begin
        n_cmp = 0; n_err = 0; loads_seen = 0; prev_load = 1'b0;
        exp_cnt = 8'd0;
        reset = 1'b0; btn_raw = 1'b0; sw_raw = 4'h0;

        // 1: reset held with random inputs
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            btn_raw = 1'($urandom_range(0, 1));
            sw_raw  = 4'($urandom_range(0, 15));
            chk("rst_nibble", {28'd0, nibble}, 32'd0);
            chk("rst_load", {31'd0, load}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_load_cnt", {24'd0, load_cnt}, 32'd0);
        end

        // 2: clean long press, latency DEB_CYCLES+3
        apply_reset();
        sw_raw = 4'hA;
        push_exp(4'hA);
        btn_raw = 1'b1;
        measure(first_k, 20);
        chk("t2_latency", first_k, 32'd7);
        btn_raw = 1'b0;
        repeat (10) @(negedge clk);
        chk("t2_busy_idle", {31'd0, busy}, 32'd0);
        chk("t2_load_cnt", {24'd0, load_cnt}, 32'd1);
        chk("t2_nibble", {28'd0, nibble}, 32'hA);

        // 3: short bounces never qualify
        apply_reset();
        base = loads_seen;
        saw_hi = 1'b0; saw_lo = 1'b0;
        for (int r = 0; r < 5; r++) begin
            btn_raw = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (busy) saw_hi = 1'b1; else saw_lo = 1'b1;
            end
            btn_raw = 1'b0;
            repeat (2) begin
                @(negedge clk);
                if (busy) saw_hi = 1'b1; else saw_lo = 1'b1;
            end
        end
        repeat (6) @(negedge clk);
        chk("t3_busy_hi", {31'd0, saw_hi}, 32'd1);
        chk("t3_busy_lo", {31'd0, saw_lo}, 32'd1);
        chk("t3_loads", loads_seen - base, 32'd0);
        chk("t3_load_cnt", {24'd0, load_cnt}, 32'd0);
        chk("t3_busy_end", {31'd0, busy}, 32'd0);

        // 4: switch change while held is ignored; release debounce timing
        apply_reset();
        base = loads_seen;
        sw_raw = 4'h3;
        push_exp(4'h3);
        btn_raw = 1'b1;
        repeat (8) @(negedge clk);
        sw_raw = 4'hC;
        repeat (50) @(negedge clk);
        chk("t4_nibble_held", {28'd0, nibble}, 32'h3);
        btn_raw = 1'b0;
        repeat (6) @(negedge clk);
        chk("t4_busy_rel_db", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("t4_busy_idle", {31'd0, busy}, 32'd0);
        chk("t4_loads", loads_seen - base, 32'd1);
        chk("t4_load_cnt", {24'd0, load_cnt}, 32'd1);
        chk("t4_nibble_end", {28'd0, nibble}, 32'h3);

        // 5: reset during PRESS_DB, button held through reset
        apply_reset();
        sw_raw = 4'h5;
        btn_raw = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_busy_pre", {31'd0, busy}, 32'd1);
        chk("t5_no_load_pre", {31'd0, load}, 32'd0);
        reset = 1'b0;
        exp_q.delete();
        exp_cnt = 8'd0;
        repeat (2) @(negedge clk);
        chk("t5_busy_rst", {31'd0, busy}, 32'd0);
        chk("t5_cnt_rst", {24'd0, load_cnt}, 32'd0);
        push_exp(4'h5);
        reset = 1'b1;
        measure(first_k, 12);
        chk("t5_latency", first_k, 32'd7);
        btn_raw = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_load_cnt", {24'd0, load_cnt}, 32'd1);

        // 6: 256 presses, counter wraps to zero
        apply_reset();
        base = loads_seen;
        for (int i = 0; i < 256; i++) begin
            sw_raw = i[3:0];
            push_exp(i[3:0]);
            btn_raw = 1'b1;
            repeat (10) @(negedge clk);
            btn_raw = 1'b0;
            repeat (10) @(negedge clk);
        end
        chk("t6_loads", loads_seen - base, 32'd256);
        chk("t6_load_cnt_wrap", {24'd0, load_cnt}, 32'd0);
        chk("t6_nibble_last", {28'd0, nibble}, 32'hF);
        chk("t6_queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
